// File: rtl/id_remap_pkg.sv
// Shared helpers for the ID remap allocator.
// Width helpers derive the tag and occupancy widths from the row and column
// counts. The uid helpers pack and unpack a {row,col} tag. They work on int
// values, so callers cast the result to the width they need.
package id_remap_pkg;

  function automatic int calc_uid_w(input int rows, input int cols);
    return $clog2(rows) + $clog2(cols);
  endfunction

  function automatic int calc_occ_w(input int rows, input int cols);
    return $clog2(rows * cols + 1);
  endfunction

  function automatic int uid_pack(input int row, input int col, input int col_w);
    return (row << col_w) | col;
  endfunction

  function automatic int uid_row(input int uid, input int col_w);
    return uid >> col_w;
  endfunction

  function automatic int uid_col(input int uid, input int col_w);
    return uid & ((1 << col_w) - 1);
  endfunction

endpackage

// File: rtl/id_remap_alloc_ring_first_set.sv
// Rotated priority encoder.
// Searches mask_i in ring order, starting at start_i and wrapping around.
// It returns the first set bit it finds.
// Ports:
//   mask_i  : candidate bits
//   start_i : index where the search begins (inclusive)
//   idx_o   : index of the first set bit at or after start_i
//   found_o : 1 when any bit of mask_i is set
module ring_first_set #(
  parameter int W  = 4,
  parameter int IW = $clog2(W)
) (
  input  logic [W-1:0]  mask_i,
  input  logic [IW-1:0] start_i,
  output logic [IW-1:0] idx_o,
  output logic          found_o
);

  logic [IW-1:0] j;

  always_comb begin
    idx_o   = '0;
    found_o = 1'b0;
    j       = '0;
    for (int i = 0; i < W; i++) begin
      // W is a power of two, so the IW-bit add wraps the ring for free.
      j = start_i + IW'(i);
      if (!found_o && mask_i[j]) begin
        found_o = 1'b1;
        idx_o   = j;
      end
    end
  end

endmodule

// File: rtl/id_remap_alloc.sv
// ID remap allocator.
// Maps an original AXI ID onto a unique {row,col} tag. Each row is bound to
// one ID while any of its columns is outstanding. Columns within a row are
// issued in strict ring order, so the order of tags follows the order in
// which each ID was issued. The block also tracks the oldest outstanding
// column (head) of every row.
// Ports:
//   clk, rst         : clock, synchronous active-high reset
//   alloc_valid/id   : allocation request for an original ID
//   alloc_ready/uid  : comb; the grant is possible this cycle, and the tag granted
//   free_valid/uid   : release of an outstanding tag
//   free_ready       : always 1
//   free_id          : comb; original ID stored for free_uid (qualify with !free_err)
//   free_is_oldest   : comb; free_uid is used and is its row's head
//   free_err         : comb; free_valid on an unused slot (free ignored)
//   occupancy/full/empty : registered slot-usage status
// Handshake: a transfer happens on a rising edge where valid && ready. The
// ready signals never depend on the valid signals. Every allocation decision
// is taken from the registered state.
module id_remap_alloc
  import id_remap_pkg::*;
#(
  parameter int ID_WIDTH = 4,
  parameter int NUM_ROWS = 4,
  parameter int NUM_COLS = 4,
  parameter int UID_W    = calc_uid_w(NUM_ROWS, NUM_COLS),
  parameter int OCC_W    = calc_occ_w(NUM_ROWS, NUM_COLS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                alloc_valid,
  input  logic [ID_WIDTH-1:0] alloc_id,
  output logic                alloc_ready,
  output logic [UID_W-1:0]    alloc_uid,
  input  logic                free_valid,
  input  logic [UID_W-1:0]    free_uid,
  output logic                free_ready,
  output logic [ID_WIDTH-1:0] free_id,
  output logic                free_is_oldest,
  output logic                free_err,
  output logic [OCC_W-1:0]    occupancy,
  output logic                full,
  output logic                empty
);

  localparam int ROW_W = $clog2(NUM_ROWS);
  localparam int COL_W = $clog2(NUM_COLS);
  localparam int CNT_W = $clog2(NUM_COLS + 1);
  localparam int CAP   = NUM_ROWS * NUM_COLS;

  typedef struct packed {
    logic                bound;
    logic [ID_WIDTH-1:0] id;
    logic [COL_W-1:0]    head;
    logic [COL_W-1:0]    tail;
    logic [CNT_W-1:0]    count;
  } row_state_t;

  row_state_t [NUM_ROWS-1:0]               rows_q, rows_d;
  logic [NUM_ROWS-1:0][NUM_COLS-1:0]       used_q, used_d;
  logic [CAP-1:0][ID_WIDTH-1:0]            tag_q;
  logic [OCC_W-1:0]                        occ_q, occ_d;
  logic                                    full_q, empty_q;

  // Allocation row/column select
  logic             hit, unb;
  logic [ROW_W-1:0] hit_row, unb_row, sel_row;
  logic [COL_W-1:0] sel_col;
  logic             alloc_fire;

  always_comb begin
    hit     = 1'b0;
    unb     = 1'b0;
    hit_row = '0;
    unb_row = '0;
    for (int r = 0; r < NUM_ROWS; r++) begin
      if (!hit && rows_q[r].bound && rows_q[r].id == alloc_id) begin
        hit     = 1'b1;
        hit_row = ROW_W'(r);
      end
      if (!unb && !rows_q[r].bound) begin
        unb     = 1'b1;
        unb_row = ROW_W'(r);
      end
    end
    sel_row = hit ? hit_row : unb_row;
    sel_col = rows_q[sel_row].tail;
    // Ring discipline: a used tail stalls the ID even if other columns are free.
    alloc_ready = (hit || unb) && !used_q[sel_row][sel_col];
    alloc_uid   = UID_W'(uid_pack(int'(sel_row), int'(sel_col), COL_W));
  end

  assign alloc_fire = alloc_valid && alloc_ready;

  // Free decode
  logic [ROW_W-1:0]    f_row;
  logic [COL_W-1:0]    f_col;
  logic                f_used;
  logic                free_fire;
  logic [NUM_COLS-1:0] post_mask;
  logic [COL_W-1:0]    nxt_head;
  logic                nxt_found;

  always_comb begin
    f_row            = ROW_W'(uid_row(int'(free_uid), COL_W));
    f_col            = COL_W'(uid_col(int'(free_uid), COL_W));
    f_used           = used_q[f_row][f_col];
    post_mask        = used_q[f_row];
    post_mask[f_col] = 1'b0;
  end

  assign free_ready     = 1'b1;
  assign free_err       = free_valid && !f_used;
  assign free_fire      = free_valid && f_used;
  assign free_is_oldest = f_used && (f_col == rows_q[f_row].head);
  assign free_id        = tag_q[free_uid];

  // Next oldest column after the current head, once the freed column is excluded.
  ring_first_set #(.W(NUM_COLS)) u_head_adv (
    .mask_i  (post_mask),
    .start_i (rows_q[f_row].head + COL_W'(1)),
    .idx_o   (nxt_head),
    .found_o (nxt_found)
  );

  // Next state
  logic [CNT_W-1:0] cnt;

  always_comb begin
    rows_d = rows_q;
    used_d = used_q;
    occ_d  = occ_q;
    cnt    = '0;

    if (alloc_fire) begin
      used_d[sel_row][sel_col] = 1'b1;
      rows_d[sel_row].tail     = sel_col + COL_W'(1);
      if (!hit) begin
        rows_d[sel_row].bound = 1'b1;
        rows_d[sel_row].id    = alloc_id;
        rows_d[sel_row].head  = sel_col;
      end
      occ_d = occ_d + OCC_W'(1);
    end

    if (free_fire) begin
      used_d[f_row][f_col] = 1'b0;
      if (f_col == rows_q[f_row].head) begin
        if (rows_q[f_row].count > CNT_W'(1)) begin
          rows_d[f_row].head = nxt_found ? nxt_head : rows_q[f_row].head;
        end else if (alloc_fire && sel_row == f_row) begin
          // The only slot is freed while the row is refilled, so the new slot becomes oldest.
          rows_d[f_row].head = sel_col;
        end
      end
      occ_d = occ_d - OCC_W'(1);
    end

    for (int r = 0; r < NUM_ROWS; r++) begin
      cnt = rows_q[r].count;
      if (alloc_fire && sel_row == ROW_W'(r)) cnt = cnt + CNT_W'(1);
      if (free_fire && f_row == ROW_W'(r))    cnt = cnt - CNT_W'(1);
      rows_d[r].count = cnt;
      // Release an emptied row. The tail is kept so that column rotation continues.
      if (rows_q[r].bound && cnt == '0 && !(alloc_fire && sel_row == ROW_W'(r))) begin
        rows_d[r].bound = 1'b0;
        rows_d[r].id    = '0;
        rows_d[r].head  = rows_d[r].tail;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rows_q  <= '0;
      used_q  <= '0;
      tag_q   <= '0;
      occ_q   <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
    end else begin
      rows_q  <= rows_d;
      used_q  <= used_d;
      occ_q   <= occ_d;
      full_q  <= (occ_d == OCC_W'(CAP));
      empty_q <= (occ_d == '0);
      if (alloc_fire) tag_q[alloc_uid] <= alloc_id;
    end
  end

  assign occupancy = occ_q;
  assign full      = full_q;
  assign empty     = empty_q;

endmodule

// File: tb/tb_id_remap_alloc.sv
module tb_id_remap_alloc;

  localparam int C_AR  = 1;
  localparam int C_UID = 2;
  localparam int C_FID = 4;
  localparam int C_OLD = 8;
  localparam int C_ERR = 16;
  localparam int C_OCC = 32;

  logic       clk = 1'b0;
  logic       rst;
  logic       alloc_valid;
  logic [3:0] alloc_id;
  logic       alloc_ready;
  logic [3:0] alloc_uid;
  logic       free_valid;
  logic [3:0] free_uid;
  logic       free_ready;
  logic [3:0] free_id;
  logic       free_is_oldest;
  logic       free_err;
  logic [4:0] occupancy;
  logic       full;
  logic       empty;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  id_remap_alloc dut (
    .clk            (clk),
    .rst            (rst),
    .alloc_valid    (alloc_valid),
    .alloc_id       (alloc_id),
    .alloc_ready    (alloc_ready),
    .alloc_uid      (alloc_uid),
    .free_valid     (free_valid),
    .free_uid       (free_uid),
    .free_ready     (free_ready),
    .free_id        (free_id),
    .free_is_oldest (free_is_oldest),
    .free_err       (free_err),
    .occupancy      (occupancy),
    .full           (full),
    .empty          (empty)
  );

  typedef struct {
    string      name;
    logic       rst;
    logic       av;
    logic [3:0] aid;
    logic       fv;
    logic [3:0] fuid;
    int         chk;
    logic       e_ar;
    logic [3:0] e_uid;
    logic [3:0] e_fid;
    logic       e_old;
    logic       e_err;
    logic [4:0] e_occ;
    logic       e_empty;
    logic       e_full;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input string name, input logic r, input logic av, input logic [3:0] aid,
                     input logic fv, input logic [3:0] fuid, input int chk,
                     input logic ar, input logic [3:0] uid, input logic [3:0] fid,
                     input logic old, input logic err, input logic [4:0] occ,
                     input logic emp, input logic ful);
    vec_t v;
    v.name = name; v.rst = r; v.av = av; v.aid = aid; v.fv = fv; v.fuid = fuid;
    v.chk = chk; v.e_ar = ar; v.e_uid = uid; v.e_fid = fid; v.e_old = old;
    v.e_err = err; v.e_occ = occ; v.e_empty = emp; v.e_full = ful;
    vecs.push_back(v);
  endtask

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic av, input logic [3:0] aid,
                       input logic fv, input logic [3:0] fuid);
    @(negedge clk);
    rst = r; alloc_valid = av; alloc_id = aid; free_valid = fv; free_uid = fuid;
    #1;
  endtask

  initial begin
    rst = 1'b1; alloc_valid = 1'b0; alloc_id = '0; free_valid = 1'b0; free_uid = '0;

    // name, rst, av, aid, fv, fuid, chk, ar, uid, fid, old, err, occ, empty, full
    add("rst0",      1, 0, 4'h0, 0, 4'h0, 0,                                  0, 4'h0, 4'h0, 0, 0, 0, 1, 0);
    add("a3_0",      0, 1, 4'h3, 0, 4'h0, C_AR|C_UID|C_ERR|C_OCC,             1, 4'h0, 4'h0, 0, 0, 0, 1, 0);
    add("a3_1",      0, 1, 4'h3, 0, 4'h0, C_AR|C_UID|C_OCC,                   1, 4'h1, 4'h0, 0, 0, 1, 0, 0);
    add("a3_2",      0, 1, 4'h3, 0, 4'h0, C_AR|C_UID|C_OCC,                   1, 4'h2, 4'h0, 0, 0, 2, 0, 0);
    add("peek3",     0, 0, 4'h3, 0, 4'h1, C_AR|C_UID|C_FID|C_OLD|C_ERR|C_OCC, 1, 4'h3, 4'h3, 0, 0, 3, 0, 0);
    add("rst1",      1, 0, 4'h0, 0, 4'h0, C_OCC,                              0, 4'h0, 4'h0, 0, 0, 3, 0, 0);
    add("err_rst",   0, 0, 4'h5, 1, 4'hF, C_AR|C_UID|C_FID|C_OLD|C_ERR|C_OCC, 1, 4'h0, 4'h0, 0, 1, 0, 1, 0);
    add("a5_0",      0, 1, 4'h5, 0, 4'h0, C_AR|C_UID|C_OCC,                   1, 4'h0, 4'h0, 0, 0, 0, 1, 0);
    add("a5_1",      0, 1, 4'h5, 0, 4'h0, C_AR|C_UID|C_OCC,                   1, 4'h1, 4'h0, 0, 0, 1, 0, 0);
    add("a5_2",      0, 1, 4'h5, 0, 4'h0, C_AR|C_UID|C_OCC,                   1, 4'h2, 4'h0, 0, 0, 2, 0, 0);
    add("a5_3",      0, 1, 4'h5, 0, 4'h0, C_AR|C_UID|C_OCC,                   1, 4'h3, 4'h0, 0, 0, 3, 0, 0);
    add("stall_f2",  0, 0, 4'h5, 1, 4'h2, C_AR|C_FID|C_OLD|C_ERR|C_OCC,       0, 4'h0, 4'h5, 0, 0, 4, 0, 0);
    add("stall_f0",  0, 0, 4'h5, 1, 4'h0, C_AR|C_OLD|C_ERR|C_OCC,             0, 4'h0, 4'h0, 1, 0, 3, 0, 0);
    add("unstall",   0, 1, 4'h5, 0, 4'h0, C_AR|C_UID|C_OCC,                   1, 4'h0, 4'h0, 0, 0, 2, 0, 0);
    add("f1",        0, 0, 4'h5, 1, 4'h1, C_OLD|C_ERR|C_OCC,                  0, 4'h0, 4'h0, 1, 0, 3, 0, 0);
    add("f3",        0, 0, 4'h5, 1, 4'h3, C_OLD|C_OCC,                        0, 4'h0, 4'h0, 1, 0, 2, 0, 0);
    add("f0",        0, 0, 4'h5, 1, 4'h0, C_OLD|C_OCC,                        0, 4'h0, 4'h0, 1, 0, 1, 0, 0);
    add("rst2",      1, 0, 4'h0, 0, 4'h0, C_OCC,                              0, 4'h0, 4'h0, 0, 0, 0, 1, 0);
    add("a7_0",      0, 1, 4'h7, 0, 4'h0, C_AR|C_UID|C_OCC,                   1, 4'h0, 4'h0, 0, 0, 0, 1, 0);
    add("a7_1",      0, 1, 4'h7, 0, 4'h0, C_AR|C_UID|C_OCC,                   1, 4'h1, 4'h0, 0, 0, 1, 0, 0);
    add("a7_2",      0, 1, 4'h7, 0, 4'h0, C_AR|C_UID|C_OCC,                   1, 4'h2, 4'h0, 0, 0, 2, 0, 0);
    add("o_f1",      0, 0, 4'h7, 1, 4'h1, C_FID|C_OLD|C_ERR|C_OCC,            0, 4'h0, 4'h7, 0, 0, 3, 0, 0);
    add("o_f0",      0, 0, 4'h7, 1, 4'h0, C_OLD|C_OCC,                        0, 4'h0, 4'h0, 1, 0, 2, 0, 0);
    add("o_f2",      0, 0, 4'h7, 1, 4'h2, C_OLD|C_OCC,                        0, 4'h0, 4'h0, 1, 0, 1, 0, 0);
    add("rel",       0, 0, 4'h8, 0, 4'h0, C_AR|C_UID|C_OCC,                   1, 4'h3, 4'h0, 0, 0, 0, 1, 0);
    add("rst3",      1, 0, 4'h0, 0, 4'h0, 0,                                  0, 4'h0, 4'h0, 0, 0, 0, 1, 0);
    add("d1",        0, 1, 4'h1, 0, 4'h0, C_AR|C_UID|C_OCC,                   1, 4'h0, 4'h0, 0, 0, 0, 1, 0);
    add("d2",        0, 1, 4'h2, 0, 4'h0, C_AR|C_UID|C_OCC,                   1, 4'h4, 4'h0, 0, 0, 1, 0, 0);
    add("d3",        0, 1, 4'h3, 0, 4'h0, C_AR|C_UID|C_OCC,                   1, 4'h8, 4'h0, 0, 0, 2, 0, 0);
    add("d4",        0, 1, 4'h4, 0, 4'h0, C_AR|C_UID|C_OCC,                   1, 4'hC, 4'h0, 0, 0, 3, 0, 0);
    add("d9_stall",  0, 1, 4'h9, 0, 4'h0, C_AR|C_OCC,                         0, 4'h0, 4'h0, 0, 0, 4, 0, 0);
    add("d9_f8",     0, 1, 4'h9, 1, 4'h8, C_AR|C_FID|C_OLD|C_ERR|C_OCC,       0, 4'h0, 4'h3, 1, 0, 4, 0, 0);
    add("d9_go",     0, 1, 4'h9, 0, 4'h0, C_AR|C_UID|C_OCC,                   1, 4'h9, 4'h0, 0, 0, 3, 0, 0);
    add("same",      0, 1, 4'h1, 1, 4'h0, C_AR|C_UID|C_OLD|C_ERR|C_OCC,       1, 4'h1, 4'h0, 1, 0, 4, 0, 0);
    add("same_chk",  0, 0, 4'h5, 0, 4'h1, C_AR|C_FID|C_OLD|C_OCC,             0, 4'h0, 4'h1, 1, 0, 4, 0, 0);
    add("bad_free",  0, 0, 4'h5, 1, 4'hF, C_FID|C_ERR|C_OCC,                  0, 4'h0, 4'h0, 0, 1, 4, 0, 0);
    add("post_bad",  0, 1, 4'h1, 0, 4'h0, C_AR|C_UID|C_OCC,                   1, 4'h2, 4'h0, 0, 0, 4, 0, 0);
    add("rst_mid",   1, 1, 4'h2, 0, 4'h0, C_OCC,                              0, 4'h0, 4'h0, 0, 0, 5, 0, 0);
    add("after_rst", 0, 0, 4'h2, 0, 4'h0, C_AR|C_UID|C_OCC,                   1, 4'h0, 4'h0, 0, 0, 0, 1, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].rst, vecs[i].av, vecs[i].aid, vecs[i].fv, vecs[i].fuid);
      if ((vecs[i].chk & C_AR) != 0)  cmp({vecs[i].name, "/alloc_ready"}, 32'(alloc_ready), 32'(vecs[i].e_ar));
      if ((vecs[i].chk & C_UID) != 0) cmp({vecs[i].name, "/alloc_uid"}, 32'(alloc_uid), 32'(vecs[i].e_uid));
      if ((vecs[i].chk & C_FID) != 0) cmp({vecs[i].name, "/free_id"}, 32'(free_id), 32'(vecs[i].e_fid));
      if ((vecs[i].chk & C_OLD) != 0) cmp({vecs[i].name, "/free_is_oldest"}, 32'(free_is_oldest), 32'(vecs[i].e_old));
      if ((vecs[i].chk & C_ERR) != 0) cmp({vecs[i].name, "/free_err"}, 32'(free_err), 32'(vecs[i].e_err));
      if ((vecs[i].chk & C_OCC) != 0) begin
        cmp({vecs[i].name, "/occupancy"}, 32'(occupancy), 32'(vecs[i].e_occ));
        cmp({vecs[i].name, "/empty"}, 32'(empty), 32'(vecs[i].e_empty));
        cmp({vecs[i].name, "/full"}, 32'(full), 32'(vecs[i].e_full));
      end
      cmp({vecs[i].name, "/free_ready"}, 32'(free_ready), 32'd1);
    end

    // Fill to capacity: after reset, ID k binds row k and the tags come out as 0..15.
    for (int i = 0; i < 16; i++) begin
      drive(1'b0, 1'b1, 4'(i / 4), 1'b0, 4'h0);
      cmp($sformatf("fill%0d/alloc_ready", i), 32'(alloc_ready), 32'd1);
      cmp($sformatf("fill%0d/alloc_uid", i), 32'(alloc_uid), 32'(i));
    end
    drive(1'b0, 1'b1, 4'h0, 1'b0, 4'h0);
    cmp("full/alloc_ready", 32'(alloc_ready), 32'd0);
    cmp("full/occupancy", 32'(occupancy), 32'd16);
    cmp("full/full", 32'(full), 32'd1);
    cmp("full/empty", 32'(empty), 32'd0);

    // Drain in issue order: every freed tag is the head of its row.
    for (int i = 0; i < 16; i++) begin
      drive(1'b0, 1'b0, 4'h0, 1'b1, 4'(i));
      cmp($sformatf("drain%0d/free_err", i), 32'(free_err), 32'd0);
      cmp($sformatf("drain%0d/free_id", i), 32'(free_id), 32'(i / 4));
      cmp($sformatf("drain%0d/free_is_oldest", i), 32'(free_is_oldest), 32'd1);
    end
    drive(1'b0, 1'b0, 4'h0, 1'b0, 4'h0);
    cmp("drained/occupancy", 32'(occupancy), 32'd0);
    cmp("drained/empty", 32'(empty), 32'd1);
    cmp("drained/full", 32'(full), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
